acceso_memoria: RTL and testbench
=================================

# acceso_memoria

Load/store unit between the multicycle RV32I control FSM/datapath and the synchronous data RAM. It sits downstream of the control state machine's memory phase: on a start pulse it performs one byte, halfword or word access. It generates byte enables and the replicated store data, waits a configurable read latency, then returns sign- or zero-extended load data with a one-cycle done pulse. Misaligned or invalid accesses never reach memory and are flagged instead.

## Interface
- LATENCIA, 1, RAM read latency in cycles (legal 1..4)
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  synchronous, active-high
- inicio  in  1  start pulse, sampled only in REPOSO
- escribe  in  1  1 = store, 0 = load (sampled with inicio)
- funct3  in  3  RV32I width/sign code (sampled with inicio)
- dir  in  32  byte address (ALU result, sampled with inicio)
- dat_esc  in  32  rs2 store data (sampled with inicio)
- ocupado  out  1  high in every state except REPOSO
- listo  out  1  one-cycle done pulse
- error_alineacion  out  1  one-cycle pulse, coincident with listo, on bad access
- dat_lec  out  32  extended load result, held until next successful load
- mem_dir  out  32  word address {dir_lat[31:2],2'b00}
- mem_esc  out  1  RAM write strobe
- mem_be  out  4  byte enables
- mem_dat_esc  out  32  replicated store data
- mem_dat_lec  in  32  RAM read word

## Operation
- States: REPOSO, ACCESO, ESPERA, FIN. Encoding is free.
- REPOSO: when inicio=1, latch escribe, funct3, dir and dat_esc. Go to ACCESO, or to FIN directly if the access is bad.
- Bad access:
  - loads with funct3 3, 6 or 7; stores with funct3 ≥3;
  - LH/LHU/SH with dir[0]=1; LW/SW with dir[1:0]≠0.
- Handling of a bad access:
  - no mem_esc, mem_be stays 0;
  - error_alineacion and listo pulse together in FIN;
  - dat_lec is left unchanged.
- ACCESO:
  - drive mem_be from the latched values; for stores, also drive mem_esc=1.
  - Store exits to FIN.
  - Load exits to FIN if LATENCIA=1, else to ESPERA.
- ESPERA: a counter runs LATENCIA-1 cycles with mem_be held, then goes to FIN.
  - Loads capture mem_dat_lec on the last address-valid cycle (ACCESO when LATENCIA=1, else the final ESPERA cycle).
- FIN: listo=1 for exactly one cycle, then REPOSO.
- Byte enables:
  - SB: 4'b0001<<dir[1:0];
  - SH: 4'b0011<<dir[1:0];
  - SW: 4'b1111.
- Store data:
  - SB: {4{dat_esc[7:0]}};
  - SH: {2{dat_esc[15:0]}};
  - SW: dat_esc.
- Load extract: word shifted right by 8*dir[1:0], then:
  - LB (0): sign-extend bit 7; LBU (4): zero-extend byte;
  - LH (1): sign-extend bit 15; LHU (5): zero-extend halfword;
  - LW (2): whole word.
- mem_be is 0 and mem_esc is 0 outside ACCESO/ESPERA.
- mem_dir and mem_dat_esc always reflect the latched values.
- inicio is ignored while ocupado=1. No queueing.

## Timing
- Reset values:
  - state REPOSO, ocupado 0, listo 0, error_alineacion 0;
  - dat_lec 0, mem_esc 0, mem_be 0, mem_dir 0, mem_dat_esc 0, all latches 0.
- Reset during any state:
  - return to REPOSO next edge;
  - the access is aborted, with no listo and no further mem_esc.
- inicio is sampled at edge t. The cycles that follow:
  - Store: ACCESO in t+1, with mem_esc high for exactly one cycle; listo in t+2.
  - Load: address valid t+1..t+LATENCIA; listo in t+LATENCIA+1.
  - Bad access: listo and error_alineacion in t+1.
- dat_lec updates at the same edge that enters FIN, so it is valid while listo=1 and afterwards.
- inicio asserted in the same cycle as listo is ignored. The next inicio is accepted in the cycle after FIN.

## Test plan
- Store word, LATENCIA=1: SW, dir=0x100, dat_esc=0xDEADBEEF → at t+1 mem_esc=1, mem_be=1111, mem_dir=0x100, mem_dat_esc=0xDEADBEEF; listo at t+2 and nowhere else.
- Store byte: SB, dir=0x102, dat_esc=0x000000A5 → mem_be=0100, mem_dat_esc=0xA5A5A5A5, mem_dir=0x100.
- Signed vs unsigned loads, RAM word 0x80FF7F01 at 0x200:
  - LB 0x203 → 0xFFFFFF80; LBU 0x203 → 0x00000080;
  - LH 0x200 → 0x00007F01; LHU 0x202 → 0x000080FF;
  - LW 0x200 → 0x80FF7F01.
- Misaligned access: LW dir=0x201 → listo and error_alineacion at t+1, mem_be never nonzero, dat_lec unchanged. Same for SH dir=0x203: no mem_esc.
- LATENCIA=3 load: LW dir=0x40, RAM returns 0x12345678 three cycles after the address → mem_be=1111 during t+1..t+3, listo at t+4 with dat_lec=0x12345678. A second inicio at t+2 is ignored.
- Reset mid-load: LATENCIA=3, reset asserted at t+2 → REPOSO next edge, ocupado=0, no listo. A subsequent LW completes normally.

Source files
------------

// File: rtl/acceso_memoria_if.sv
// Request/response and RAM-side signals of the load/store unit.
// The slave modport is the unit itself; the master modport is its environment.
interface acceso_memoria_if;
  logic        inicio;
  logic        escribe;
  logic [2:0]  funct3;
  logic [31:0] dir;
  logic [31:0] dat_esc;
  logic        ocupado;
  logic        listo;
  logic        error_alineacion;
  logic [31:0] dat_lec;
  logic [31:0] mem_dir;
  logic        mem_esc;
  logic [3:0]  mem_be;
  logic [31:0] mem_dat_esc;
  logic [31:0] mem_dat_lec;

  modport slave (
    input  inicio, escribe, funct3, dir, dat_esc, mem_dat_lec,
    output ocupado, listo, error_alineacion, dat_lec, mem_dir, mem_esc, mem_be, mem_dat_esc
  );

  modport master (
    output inicio, escribe, funct3, dir, dat_esc, mem_dat_lec,
    input  ocupado, listo, error_alineacion, dat_lec, mem_dir, mem_esc, mem_be, mem_dat_esc
  );
endinterface

// File: rtl/acceso_memoria.sv
// RV32I load/store unit: one byte/halfword/word access per start pulse against a
// synchronous RAM with configurable read latency; bad accesses are flagged, never issued.
module acceso_memoria #(
  parameter int unsigned LATENCIA = 1
) (
  input logic             clk,
  input logic             reset,
  acceso_memoria_if.slave bus
);

  typedef enum logic [1:0] {StReposo, StAcceso, StEspera, StFin} estado_t;

  // ESPERA lasts LATENCIA-1 cycles; the counter counts down to zero inclusive.
  localparam logic [1:0] CuentaIni = (LATENCIA > 1) ? 2'(LATENCIA - 2) : 2'd0;

  estado_t     estado;
  logic        escribe_lat;
  logic [2:0]  funct3_lat;
  logic [31:0] dir_lat;
  logic [31:0] dat_esc_lat;
  logic [1:0]  cuenta;
  logic        listo;
  logic        error_alineacion;
  logic        mem_esc;
  logic [3:0]  mem_be;
  logic [31:0] dat_lec;

  logic        malo;
  logic [3:0]  be_nuevo;
  logic [31:0] desplazado;
  logic [31:0] lec_ext;
  logic [31:0] dat_rep;

  function automatic logic acceso_malo(input logic esc, input logic [2:0] f3,
                                       input logic [1:0] a);
    logic m;
    case (f3)
      3'd0:    m = 1'b0;
      3'd1:    m = a[0];
      3'd2:    m = (a != 2'b00);
      3'd4:    m = esc;
      3'd5:    m = esc | a[0];
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] calc_be(input logic [1:0] ancho, input logic [1:0] a);
    logic [3:0] be;
    case (ancho)
      2'd0:    be = 4'b0001 << a;
      2'd1:    be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  assign malo     = acceso_malo(bus.escribe, bus.funct3, bus.dir[1:0]);
  assign be_nuevo = calc_be(bus.funct3[1:0], bus.dir[1:0]);

  assign desplazado = bus.mem_dat_lec >> {dir_lat[1:0], 3'b000};

  always_comb begin
    lec_ext = desplazado;
    case (funct3_lat)
      3'd0:    lec_ext = {{24{desplazado[7]}}, desplazado[7:0]};
      3'd1:    lec_ext = {{16{desplazado[15]}}, desplazado[15:0]};
      3'd4:    lec_ext = {24'd0, desplazado[7:0]};
      3'd5:    lec_ext = {16'd0, desplazado[15:0]};
      default: lec_ext = desplazado;
    endcase
  end

  always_comb begin
    dat_rep = dat_esc_lat;
    case (funct3_lat[1:0])
      2'd0:    dat_rep = {4{dat_esc_lat[7:0]}};
      2'd1:    dat_rep = {2{dat_esc_lat[15:0]}};
      default: dat_rep = dat_esc_lat;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado           <= StReposo;
      escribe_lat      <= 1'b0;
      funct3_lat       <= 3'd0;
      dir_lat          <= 32'd0;
      dat_esc_lat      <= 32'd0;
      cuenta           <= 2'd0;
      listo            <= 1'b0;
      error_alineacion <= 1'b0;
      mem_esc          <= 1'b0;
      mem_be           <= 4'd0;
      dat_lec          <= 32'd0;
    end else begin
      listo            <= 1'b0;
      error_alineacion <= 1'b0;
      mem_esc          <= 1'b0;
      case (estado)
        StReposo: begin
          if (bus.inicio) begin
            escribe_lat <= bus.escribe;
            funct3_lat  <= bus.funct3;
            dir_lat     <= bus.dir;
            dat_esc_lat <= bus.dat_esc;
            if (malo) begin
              estado           <= StFin;
              listo            <= 1'b1;
              error_alineacion <= 1'b1;
            end else begin
              estado  <= StAcceso;
              mem_be  <= be_nuevo;
              mem_esc <= bus.escribe;
            end
          end
        end
        StAcceso: begin
          if (escribe_lat || LATENCIA <= 1) begin
            estado <= StFin;
            listo  <= 1'b1;
            mem_be <= 4'd0;
            if (!escribe_lat) dat_lec <= lec_ext;
          end else begin
            estado <= StEspera;
            cuenta <= CuentaIni;
          end
        end
        StEspera: begin
          if (cuenta == 2'd0) begin
            estado  <= StFin;
            listo   <= 1'b1;
            mem_be  <= 4'd0;
            dat_lec <= lec_ext;
          end else begin
            cuenta <= cuenta - 2'd1;
          end
        end
        StFin:   estado <= StReposo;
        default: estado <= StReposo;
      endcase
    end
  end

  assign bus.ocupado          = (estado != StReposo);
  assign bus.listo            = listo;
  assign bus.error_alineacion = error_alineacion;
  assign bus.dat_lec          = dat_lec;
  assign bus.mem_dir          = {dir_lat[31:2], 2'b00};
  assign bus.mem_esc          = mem_esc;
  assign bus.mem_be           = mem_be;
  assign bus.mem_dat_esc      = dat_rep;

endmodule

// File: tb/tb_acceso_memoria.sv
// Bench for acceso_memoria: one instance with read latency 1 and one with latency 3,
// driven in parallel, with a scoreboard of expected completions per instance.
module tb_acceso_memoria;

  localparam int unsigned LatLenta = 3;
  localparam int unsigned Pal40    = 16;
  localparam int unsigned Pal200   = 128;

  typedef struct {
    int unsigned ciclo;
    logic        err;
    logic [31:0] dato;
  } esperado_t;

  logic        clk = 1'b0;
  logic        reset1, reset3, precarga;
  logic        inicio, escribe;
  logic [2:0]  funct3;
  logic [31:0] dir, dat_esc;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  esperado_t   q1[$];
  esperado_t   q3[$];
  esperado_t   e1, e3;
  logic [31:0] ref_mem [256];
  logic [31:0] ram1 [256];
  logic [31:0] ram3 [256];
  logic [31:0] p1, p2;
  logic [31:0] ult1, ult3;
  int unsigned esc1 = 0, esc3 = 0, be1 = 0, be3 = 0;

  logic [2:0]  tab_f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  logic [31:0] tab_dir [5] = '{32'h203, 32'h203, 32'h200, 32'h202, 32'h200};
  logic [31:0] tab_exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'h000080FF,
                               32'h80FF7F01};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  acceso_memoria_if b1 ();
  acceso_memoria_if b3 ();

  acceso_memoria #(.LATENCIA(1)) dut1 (.clk(clk), .reset(reset1), .bus(b1.slave));
  acceso_memoria #(.LATENCIA(LatLenta)) dut3 (.clk(clk), .reset(reset3), .bus(b3.slave));

  assign b1.inicio  = inicio;
  assign b1.escribe = escribe;
  assign b1.funct3  = funct3;
  assign b1.dir     = dir;
  assign b1.dat_esc = dat_esc;
  assign b3.inicio  = inicio;
  assign b3.escribe = escribe;
  assign b3.funct3  = funct3;
  assign b3.dir     = dir;
  assign b3.dat_esc = dat_esc;

  // Latency-1 RAM answers in the address cycle; latency-3 RAM two cycles later.
  assign b1.mem_dat_lec = ram1[b1.mem_dir[9:2]];
  always @(posedge clk) begin
    p1 <= ram3[b3.mem_dir[9:2]];
    p2 <= p1;
  end
  assign b3.mem_dat_lec = p2;

  always @(posedge clk) begin
    if (precarga) begin
      ram1[Pal200] <= 32'h80FF7F01;
      ram1[Pal40]  <= 32'h12345678;
      ram3[Pal200] <= 32'h80FF7F01;
      ram3[Pal40]  <= 32'h12345678;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (b1.mem_esc && b1.mem_be[i]) ram1[b1.mem_dir[9:2]][8*i +: 8] <= b1.mem_dat_esc[8*i +: 8];
        if (b3.mem_esc && b3.mem_be[i]) ram3[b3.mem_dir[9:2]][8*i +: 8] <= b3.mem_dat_esc[8*i +: 8];
      end
    end
  end

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h (cyc %0d)", tag, obs, esp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (b1.mem_esc) esc1++;
    if (b3.mem_esc) esc3++;
    if (b1.mem_be != 4'd0) be1++;
    if (b3.mem_be != 4'd0) be3++;
    if (b1.listo) begin
      chequear("listo_esperado1", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chequear("ciclo_listo1", cyc, e1.ciclo);
        chequear("error1", {31'd0, b1.error_alineacion}, {31'd0, e1.err});
        chequear("dat_lec1", b1.dat_lec, e1.dato);
      end
    end else begin
      chequear("error_sin_listo1", {31'd0, b1.error_alineacion}, 32'd0);
    end
    if (b3.listo) begin
      chequear("listo_esperado3", 32'(q3.size() != 0), 32'd1);
      if (q3.size() != 0) begin
        e3 = q3.pop_front();
        chequear("ciclo_listo3", cyc, e3.ciclo);
        chequear("error3", {31'd0, b3.error_alineacion}, {31'd0, e3.err});
        chequear("dat_lec3", b3.dat_lec, e3.dato);
      end
    end else begin
      chequear("error_sin_listo3", {31'd0, b3.error_alineacion}, 32'd0);
    end
  end

  function automatic logic modelo_malo(input logic esc, input logic [2:0] f3,
                                       input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (esc && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelo_carga(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    int          ofs;
    w   = ref_mem[a[9:2]];
    ofs = 8 * int'(a[1:0]);
    b   = w[ofs +: 8];
    h   = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'd0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  task automatic modelo_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int ofs;
    ofs = 8 * int'(a[1:0]);
    case (f3)
      3'd0:    ref_mem[a[9:2]][ofs +: 8] = d[7:0];
      3'd1:    if (a[1]) ref_mem[a[9:2]][31:16] = d[15:0];
               else ref_mem[a[9:2]][15:0] = d[15:0];
      default: ref_mem[a[9:2]] = d;
    endcase
  endtask

  // Issues one access sampled at the next rising edge; returns mid-cycle t+1.
  task automatic acceso(input logic esc, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input bit con3);
    int unsigned t;
    logic        malo;
    esperado_t   x;
    @(negedge clk);
    inicio  = 1'b1;
    escribe = esc;
    funct3  = f3;
    dir     = a;
    dat_esc = d;
    t       = cyc;
    malo    = modelo_malo(esc, f3, a);
    if (!malo && esc) modelo_store(f3, a, d);
    if (!malo && !esc) begin
      ult1 = modelo_carga(f3, a);
      if (con3) ult3 = ult1;
    end
    x.err   = malo;
    x.dato  = ult1;
    x.ciclo = malo ? t + 1 : t + 2;
    q1.push_back(x);
    if (con3) begin
      x.dato  = ult3;
      x.ciclo = malo ? t + 1 : (esc ? t + 2 : t + LatLenta + 1);
      q3.push_back(x);
    end
    @(negedge clk);
    inicio = 1'b0;
  endtask

  task automatic esperar();
    int n;
    n = 0;
    while ((b1.ocupado || b3.ocupado || q1.size() != 0 || q3.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chequear("ocupado_fin", {30'd0, b1.ocupado, b3.ocupado}, 32'd0);
    chequear("pendientes", 32'(q1.size() + q3.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int unsigned s_esc1, s_esc3, s_be1, s_be3;
    inicio   = 1'b0;
    escribe  = 1'b0;
    funct3   = 3'd0;
    dir      = 32'd0;
    dat_esc  = 32'd0;
    reset1   = 1'b1;
    reset3   = 1'b1;
    precarga = 1'b1;
    ult1     = 32'd0;
    ult3     = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    ref_mem[Pal200] = 32'h80FF7F01;
    ref_mem[Pal40]  = 32'h12345678;
    repeat (3) @(negedge clk);
    reset1   = 1'b0;
    reset3   = 1'b0;
    precarga = 1'b0;

    chequear("rst_ocupado", {30'd0, b1.ocupado, b3.ocupado}, 32'd0);
    chequear("rst_listo_err", {28'd0, b1.listo, b3.listo, b1.error_alineacion,
                               b3.error_alineacion}, 32'd0);
    chequear("rst_dat_lec1", b1.dat_lec, 32'd0);
    chequear("rst_dat_lec3", b3.dat_lec, 32'd0);
    chequear("rst_mem_be_esc", {22'd0, b1.mem_be, b3.mem_be, b1.mem_esc, b3.mem_esc}, 32'd0);
    chequear("rst_mem_dir", b1.mem_dir | b3.mem_dir, 32'd0);
    chequear("rst_mem_dat_esc", b1.mem_dat_esc | b3.mem_dat_esc, 32'd0);

    // Store word
    s_esc1 = esc1; s_esc3 = esc3; s_be1 = be1; s_be3 = be3;
    acceso(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 1'b1);
    chequear("sw_mem_esc", {31'd0, b1.mem_esc}, 32'd1);
    chequear("sw_mem_be", {28'd0, b1.mem_be}, 32'hF);
    chequear("sw_mem_dir", b1.mem_dir, 32'h100);
    chequear("sw_mem_dat_esc", b1.mem_dat_esc, 32'hDEADBEEF);
    esperar();
    chequear("sw_esc_ciclos1", esc1 - s_esc1, 32'd1);
    chequear("sw_esc_ciclos3", esc3 - s_esc3, 32'd1);
    chequear("sw_be_ciclos1", be1 - s_be1, 32'd1);
    chequear("sw_be_ciclos3", be3 - s_be3, 32'd1);

    // Store byte
    acceso(1'b1, 3'd0, 32'h102, 32'h000000A5, 1'b1);
    chequear("sb_mem_be", {28'd0, b3.mem_be}, 32'h4);
    chequear("sb_mem_dat_esc", b3.mem_dat_esc, 32'hA5A5A5A5);
    chequear("sb_mem_dir", b3.mem_dir, 32'h100);
    esperar();

    // Read back the merged word
    acceso(1'b0, 3'd2, 32'h100, 32'd0, 1'b1);
    esperar();
    chequear("lw_merge", b3.dat_lec, 32'hDEA5BEEF);

    for (int i = 0; i < 5; i++) begin
      acceso(1'b0, tab_f3[i], tab_dir[i], 32'd0, 1'b1);
      esperar();
      chequear("carga_tab1", b1.dat_lec, tab_exp[i]);
      chequear("carga_tab3", b3.dat_lec, tab_exp[i]);
    end

    // Misaligned load and store
    s_esc1 = esc1; s_esc3 = esc3; s_be1 = be1; s_be3 = be3;
    acceso(1'b0, 3'd2, 32'h201, 32'd0, 1'b1);
    esperar();
    acceso(1'b1, 3'd1, 32'h203, 32'h1234, 1'b1);
    esperar();
    chequear("mal_be_ciclos", (be1 - s_be1) + (be3 - s_be3), 32'd0);
    chequear("mal_esc_ciclos", (esc1 - s_esc1) + (esc3 - s_esc3), 32'd0);
    chequear("mal_dat_lec", b1.dat_lec, 32'h80FF7F01);

    // Latency-3 load with a start pulse during t+2 that must be ignored
    acceso(1'b0, 3'd2, 32'h40, 32'd0, 1'b1);
    chequear("lw3_be_t1", {28'd0, b3.mem_be}, 32'hF);
    @(negedge clk);
    chequear("lw3_be_t2", {28'd0, b3.mem_be}, 32'hF);
    inicio  = 1'b1;
    escribe = 1'b1;
    funct3  = 3'd2;
    dir     = 32'h40;
    dat_esc = 32'hFFFFFFFF;
    @(negedge clk);
    inicio = 1'b0;
    chequear("lw3_be_t3", {28'd0, b3.mem_be}, 32'hF);
    @(negedge clk);
    chequear("lw3_be_t4", {28'd0, b3.mem_be}, 32'h0);
    esperar();
    chequear("lw3_dat_lec", b3.dat_lec, 32'h12345678);

    // Reset the latency-3 unit in the middle of a load
    acceso(1'b0, 3'd2, 32'h200, 32'd0, 1'b0);
    @(negedge clk);
    reset3 = 1'b1;
    @(negedge clk);
    reset3 = 1'b0;
    ult3   = 32'd0;
    chequear("rst_med_ocupado3", {31'd0, b3.ocupado}, 32'd0);
    chequear("rst_med_listo3", {31'd0, b3.listo}, 32'd0);
    esperar();

    acceso(1'b0, 3'd2, 32'h40, 32'd0, 1'b1);
    esperar();
    chequear("tras_rst_dat_lec3", b3.dat_lec, 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
